// File: rtl/rx_frame_pkg.sv
// Shared state encoding, SIGNAL header layout and header acceptance rule
// for the receive frame sequencer.
package rx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SIGNAL,
    ST_SERVICE,
    ST_DATA,
    ST_FLUSH
  } state_t;

  localparam int SIGNAL_BITS  = 24;
  localparam int SERVICE_BITS = 16;
  localparam int RATE_LSB     = 0;
  localparam int LEN_LSB      = 5;
  localparam int PARITY_POS   = 17;
  localparam int HDR_BITS     = PARITY_POS + 1;

  // Even parity over rate..parity, R4 set, and a non-zero length within range.
  function automatic logic hdr_ok(input logic [HDR_BITS-1:0] h, input int max_len);
    logic [11:0] len;
    len = h[LEN_LSB +: 12];
    return (^h == 1'b0) && h[RATE_LSB + 3] && (len != 12'd0) && (32'(len) <= 32'(max_len));
  endfunction

endpackage

// File: rtl/rx_byte_packer.sv
// LSB-first serial-to-byte assembler; byte_valid one cycle after the 8th bit.
// No backpressure: clr drops a partial byte and any byte completing on that edge.
module rx_byte_packer (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       clr,
  input  logic       data_vld,
  input  logic       data_bit,
  output logic       byte_last,
  output logic [7:0] byte_out,
  output logic       byte_valid
);

  logic [2:0] cnt;
  logic [6:0] sr;

  assign byte_last = data_vld && (cnt == 3'd7);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt        <= 3'd0;
      sr         <= 7'd0;
      byte_out   <= 8'd0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (clr) begin
        cnt <= 3'd0;
        sr  <= 7'd0;
      end else if (data_vld) begin
        cnt <= cnt + 3'd1;
        sr  <= {data_bit, sr[6:1]};
        if (cnt == 3'd7) begin
          byte_out   <= {data_bit, sr};
          byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rx_frame_sequencer.sv
// Parses the SIGNAL header, sequences the descrambler and packs DATA bytes.
// Byte out 3 cycles after its last bit; no backpressure, a gap or stray sof aborts.
module rx_frame_sequencer
  import rx_frame_pkg::*;
#(
  parameter int MAX_LEN = 4095
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        sof,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        ds_reset_n,
  output logic        ds_data_in,
  input  logic        ds_data_out,
  output logic        hdr_valid,
  output logic        hdr_err,
  output logic [3:0]  rate,
  output logic [11:0] length,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        frame_done,
  output logic        frame_abort,
  output logic        busy
);

  state_t              state;
  logic [14:0]         bit_cnt;
  logic [HDR_BITS-1:0] hdr_sr;
  logic [1:0]          data_vld_sr;
  logic                in_frame;
  logic                viol;
  logic                pk_last;
  logic [14:0]         data_last;

  assign in_frame  = (state == ST_SIGNAL) || (state == ST_SERVICE) || (state == ST_DATA);
  assign viol      = in_frame && (!bit_valid || sof);
  assign data_last = {length, 3'b000} - 15'd1;

  // data_vld_sr[1] lines up with ds_data_out for bits that were DATA bits.
  rx_byte_packer u_packer (
    .Clk        (Clk),
    .Reset      (Reset),
    .clr        (viol),
    .data_vld   (data_vld_sr[1]),
    .data_bit   (ds_data_out),
    .byte_last  (pk_last),
    .byte_out   (byte_out),
    .byte_valid (byte_valid)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state       <= ST_IDLE;
      bit_cnt     <= 15'd0;
      hdr_sr      <= '0;
      data_vld_sr <= 2'b00;
      ds_reset_n  <= 1'b0;
      ds_data_in  <= 1'b0;
      hdr_valid   <= 1'b0;
      hdr_err     <= 1'b0;
      rate        <= 4'd0;
      length      <= 12'd0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
    end else begin
      hdr_valid   <= 1'b0;
      hdr_err     <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      ds_data_in  <= 1'b0;
      data_vld_sr <= {data_vld_sr[0], 1'b0};
      case (state)
        ST_IDLE: begin
          if (sof && bit_valid) begin
            state      <= ST_SIGNAL;
            busy       <= 1'b1;
            ds_reset_n <= 1'b1;
            ds_data_in <= bit_in;
            hdr_sr     <= {bit_in, hdr_sr[HDR_BITS-1:1]};
            bit_cnt    <= 15'd1;
            rate       <= 4'd0;
            length     <= 12'd0;
          end
        end
        ST_SIGNAL, ST_SERVICE, ST_DATA: begin
          if (viol) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            ds_reset_n  <= 1'b0;
            frame_abort <= 1'b1;
            bit_cnt     <= 15'd0;
            data_vld_sr <= 2'b00;
          end else begin
            ds_data_in <= bit_in;
            bit_cnt    <= bit_cnt + 15'd1;
            if (state == ST_SIGNAL) begin
              if (bit_cnt < 15'(HDR_BITS))
                hdr_sr <= {bit_in, hdr_sr[HDR_BITS-1:1]};
              if (bit_cnt == 15'(SIGNAL_BITS - 1)) begin
                bit_cnt <= 15'd0;
                if (hdr_ok(hdr_sr, MAX_LEN)) begin
                  state     <= ST_SERVICE;
                  hdr_valid <= 1'b1;
                  rate      <= hdr_sr[RATE_LSB +: 4];
                  length    <= hdr_sr[LEN_LSB +: 12];
                end else begin
                  // Rejecting here also keeps a zero-length frame out of the descrambler.
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
                  ds_reset_n <= 1'b0;
                  hdr_err    <= 1'b1;
                end
              end
            end else if (state == ST_SERVICE) begin
              if (bit_cnt == 15'(SERVICE_BITS - 1)) begin
                bit_cnt <= 15'd0;
                state   <= ST_DATA;
              end
            end else begin
              data_vld_sr <= {data_vld_sr[0], 1'b1};
              if (bit_cnt == data_last) begin
                bit_cnt <= 15'd0;
                state   <= ST_FLUSH;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (pk_last) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            ds_reset_n <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Directed frames planned into per-cycle stimulus and expectation tables;
// a single compare process checks every DUT output each cycle.
module tb_rx_frame_sequencer;

  localparam int NCYC = 512;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        sof = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic        ds_reset_n, ds_data_in;
  logic        ds_data_out = 1'b0;
  logic        hdr_valid, hdr_err, byte_valid, frame_done, frame_abort, busy;
  logic [3:0]  rate;
  logic [11:0] length;
  logic [7:0]  byte_out;

  rx_frame_sequencer #(.MAX_LEN(4095)) dut (
    .Clk(Clk), .Reset(Reset), .sof(sof), .bit_in(bit_in), .bit_valid(bit_valid),
    .ds_reset_n(ds_reset_n), .ds_data_in(ds_data_in), .ds_data_out(ds_data_out),
    .hdr_valid(hdr_valid), .hdr_err(hdr_err), .rate(rate), .length(length),
    .byte_out(byte_out), .byte_valid(byte_valid), .frame_done(frame_done),
    .frame_abort(frame_abort), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Descrambler stand-in: identity with one cycle of lag, zero while held in reset.
  always @(posedge Clk) ds_data_out <= ds_reset_n ? ds_data_in : 1'b0;

  bit st_sof[NCYC], st_bv[NCYC], st_bit[NCYC], st_rst[NCYC];
  bit e_hv[NCYC], e_he[NCYC], e_bv[NCYC], e_done[NCYC], e_abort[NCYC];
  bit e_busy[NCYC], e_dsr[NCYC], e_dchk[NCYC], e_din[NCYC];
  logic [7:0]  e_byte[NCYC];
  logic [3:0]  e_rate[NCYC];
  logic [11:0] e_len[NCYC];

  int checks = 0;
  int errors = 0;
  int cur = -1;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  // kind: 0 clean, 1 bit_valid drop at v, 2 sof at v, 3 Reset low at v
  task automatic plan(input int s, input logic [3:0] r, input int len, input bit pflip,
                      input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                      input int kind, input int v);
    logic [87:0] fb;
    logic [11:0] l12;
    logic [7:0]  db[3];
    bit          good;
    int          n, p, lb, bc;
    db[0] = d0; db[1] = d1; db[2] = d2;
    l12 = 12'(len);
    fb = '0;
    for (int i = 0; i < 4; i++)  fb[i] = r[i];
    for (int i = 0; i < 12; i++) fb[5+i] = l12[i];
    fb[17] = pflip;
    for (int i = 0; i < 17; i++) fb[17] = fb[17] ^ fb[i];
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 8; i++) fb[40 + 8*k + i] = db[k][i];
    good = !pflip && r[3] && (len >= 1) && (len <= 4095);
    n = good ? 40 + 8*len : 24;
    if (kind == 0) begin
      p  = good ? s + 42 + 8*len : s + 24;
      lb = p - 1;
    end else begin
      p  = v + 1;
      lb = v;
    end
    for (int t = s; t < s + n; t++) begin
      if (kind == 1 && t == v) begin st_bv[t] = 1'b0; break; end
      if (kind == 2 && t == v) begin st_sof[t] = 1'b1; st_bv[t] = 1'b1; break; end
      st_sof[t] = (t == s);
      st_bv[t]  = 1'b1;
      st_bit[t] = fb[t-s];
      if (kind == 3 && t == v) begin st_rst[t] = 1'b0; break; end
    end
    for (int t = s + 1; t <= lb; t++) begin e_busy[t] = 1'b1; e_dsr[t] = 1'b1; end
    for (int t = s; t < s + n && t < lb; t++) begin e_dchk[t+1] = 1'b1; e_din[t+1] = fb[t-s]; end
    if (good && s + 24 <= lb) begin e_hv[s+24] = 1'b1; e_rate[s+24] = r; e_len[s+24] = l12; end
    if (!good && kind == 0) e_he[p] = 1'b1;
    if (good)
      for (int k = 0; k < len; k++) begin
        bc = s + 50 + 8*k;
        if (kind == 0 || bc <= lb) begin e_bv[bc] = 1'b1; e_byte[bc] = db[k]; end
      end
    if (good && kind == 0) e_done[p] = 1'b1;
    if (kind == 1 || kind == 2) e_abort[p] = 1'b1;
  endtask

  task automatic compare(input int c);
    chk("hdr_valid",   c, 32'(hdr_valid),   32'(e_hv[c]));
    chk("hdr_err",     c, 32'(hdr_err),     32'(e_he[c]));
    chk("byte_valid",  c, 32'(byte_valid),  32'(e_bv[c]));
    chk("frame_done",  c, 32'(frame_done),  32'(e_done[c]));
    chk("frame_abort", c, 32'(frame_abort), 32'(e_abort[c]));
    chk("busy",        c, 32'(busy),        32'(e_busy[c]));
    chk("ds_reset_n",  c, 32'(ds_reset_n),  32'(e_dsr[c]));
    if (e_bv[c]) chk("byte_out", c, 32'(byte_out), 32'(e_byte[c]));
    if (e_hv[c]) begin
      chk("rate",   c, 32'(rate),   32'(e_rate[c]));
      chk("length", c, 32'(length), 32'(e_len[c]));
    end
    if (e_dchk[c]) chk("ds_data_in", c, 32'(ds_data_in), 32'(e_din[c]));
    case (c)
      3: begin
        chk("lit_reset_rate",   c, 32'(rate),     32'h0);
        chk("lit_reset_length", c, 32'(length),   32'h0);
        chk("lit_reset_byte",   c, 32'(byte_out), 32'h0);
      end
      28: begin
        chk("lit_hdr_valid", c, 32'(hdr_valid), 32'h1);
        chk("lit_rate",      c, 32'(rate),      32'hB);
        chk("lit_length",    c, 32'(length),    32'h2);
      end
      54: chk("lit_byte0", c, 32'({byte_valid, byte_out}), 32'h1A5);
      62: begin
        chk("lit_done",  c, 32'(frame_done), 32'h1);
        chk("lit_byte1", c, 32'({byte_valid, byte_out}), 32'h13C);
      end
      88:  chk("lit_hdr_err",   c, 32'(hdr_err),     32'h1);
      89:  chk("lit_ds_rst",    c, 32'(ds_reset_n),  32'h0);
      191: chk("lit_abort",     c, 32'(frame_abort), 32'h1);
      336: begin
        chk("lit_midrst_length", c, 32'(length),   32'h0);
        chk("lit_midrst_byte",   c, 32'(byte_out), 32'h0);
        chk("lit_midrst_busy",   c, 32'(busy),     32'h0);
      end
      default: ;
    endcase
  endtask

  always @(negedge Clk) if (cur >= 1) compare(cur);

  initial begin
    for (int c = 0; c < NCYC; c++) st_rst[c] = (c >= 3);
    plan(4,   4'hB, 2, 1'b0, 8'hA5, 8'h3C, 8'h00, 0, 0);   // good frame
    plan(64,  4'hB, 2, 1'b1, 8'hA5, 8'h3C, 8'h00, 0, 0);   // parity error
    plan(92,  4'hB, 0, 1'b0, 8'h00, 8'h00, 8'h00, 0, 0);   // length 0
    plan(120, 4'h3, 1, 1'b0, 8'h77, 8'h00, 8'h00, 0, 0);   // R4 = 0
    plan(148, 4'hB, 2, 1'b0, 8'h11, 8'h22, 8'h00, 1, 190); // gap in DATA byte 0
    plan(195, 4'h9, 1, 1'b0, 8'h5A, 8'h00, 8'h00, 0, 0);   // recovers
    plan(250, 4'hB, 2, 1'b0, 8'h66, 8'h99, 8'h00, 2, 280); // sof during SERVICE
    plan(290, 4'hF, 3, 1'b0, 8'h01, 8'h02, 8'h03, 3, 335); // Reset during DATA
    plan(340, 4'h8, 1, 1'b0, 8'hC3, 8'h00, 8'h00, 0, 0);
    plan(391, 4'hD, 2, 1'b0, 8'h0F, 8'hF0, 8'h00, 0, 0);   // one cycle after frame_done
    plan(450, 4'hA, 1, 1'b0, 8'h81, 8'h00, 8'h00, 0, 0);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge Clk);
      #1;
      cur       = c;
      Reset     = st_rst[c];
      sof       = st_sof[c];
      bit_valid = st_bv[c];
      bit_in    = st_bit[c];
    end
    @(negedge Clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_frame_sequencer.md
Name: rx_frame_sequencer

Overview:
- Frame-level controller for the serial receive descrambler.
- Accepts a contiguous serial bit stream per frame and parses the 24-bit SIGNAL header itself (rate, length, parity).
- Sequences the descrambler: releases its reset for each frame, feeds it exactly 24+16+8*LENGTH bits, then holds it in reset until the next frame.
- Packs the descrambled DATA bits into bytes for the downstream MAC buffer, and reports header errors and aborted frames.

Parameters:
- MAX_LEN, 4095, largest accepted LENGTH field in bytes; range 1..4095.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-low reset.
- sof  in  1  start-of-frame; high together with SIGNAL bit 0.
- bit_in  in  1  serial frame bit, LSB-first per field.
- bit_valid  in  1  bit_in qualifier; must stay high for the whole frame once sof is seen.
- ds_reset_n  out  1  drives the descrambler Reset.
- ds_data_in  out  1  drives the descrambler data_in.
- ds_data_out  in  1  descrambler data_out; lags ds_data_in by 1 cycle.
- hdr_valid  out  1  1-cycle pulse: header accepted; rate/length valid from this cycle.
- hdr_err  out  1  1-cycle pulse: header rejected.
- rate  out  4  {R4,R3,R2,R1}, held until next sof.
- length  out  12  LENGTH field in bytes, held until next sof.
- byte_out  out  8  descrambled data byte, first received bit in byte_out[0].
- byte_valid  out  1  1-cycle qualifier for byte_out.
- frame_done  out  1  1-cycle pulse, coincident with the last byte_valid.
- frame_abort  out  1  1-cycle pulse on a mid-frame violation.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - ds_reset_n=0, ds_data_in=0.
  - All pulses 0, busy=0.
  - rate=0, length=0, byte_out=0.
  - State=IDLE, all counters 0.
- States: IDLE, SIGNAL, SERVICE, DATA, FLUSH.
- Bit counter: 15 bits, counts accepted bits within the current phase.
- IDLE:
  - ds_reset_n=0.
  - On sof&bit_valid: bit 0 is accepted, state goes to SIGNAL, ds_reset_n<=1, ds_data_in<=bit_in.
  - sof without bit_valid is ignored.
- Input pipeline:
  - Every accepted bit is registered into ds_data_in, so the descrambler sees it 1 cycle after presentation.
  - ds_reset_n rises on the same edge as the first ds_data_in.
- SIGNAL (24 bits):
  - Bits 0-3 are rate, bit 4 is reserved, bits 5-16 are length (LSB-first), bit 17 is parity, bits 18-23 are tail.
  - Decision is registered and appears in the cycle after bit 23.
  - Header is accepted when all hold: parity over bits 0-17 is even, R4=1, and 1<=length<=MAX_LEN. Then hdr_valid pulses and state goes to SERVICE.
  - Otherwise hdr_err pulses, ds_reset_n<=0, and state goes to IDLE. This also prevents a length=0 lockup in the descrambler.
- SERVICE: 16 bits forwarded, then state goes to DATA.
- DATA: 8*length bits forwarded, then state goes to FLUSH.
- Output alignment:
  - A 2-deep valid shift marks DATA bits, aligned to ds_data_out.
  - Marked bits shift into an 8-bit LSB-first assembler.
  - byte_valid goes high 3 cycles after the cycle that presented bit 8n+7.
- FLUSH:
  - Waits for the last byte_valid.
  - Pulses frame_done in that same cycle, sets ds_reset_n<=0, returns to IDLE.
- Violations (any non-IDLE state, before FLUSH):
  - Conditions: bit_valid=0, or sof=1.
  - Response: frame_abort pulse, ds_reset_n<=0, state to IDLE.
  - In-flight partial bytes are discarded and no further byte_valid is issued.
  - A sof that caused the abort does not start a new frame; upstream must re-present it.
- Inputs during FLUSH are ignored.
- The next frame may start from IDLE in the cycle after frame_done, frame_abort or hdr_err, which gives the descrambler at least 1 reset cycle.
- Reset mid-frame: all outputs return to reset values on the next edge and no pulses are issued.

Decomposition:
- Package rx_frame_pkg holds:
  - State enum.
  - Constants SIGNAL_BITS=24, SERVICE_BITS=16, RATE_LSB=0, LEN_LSB=5, PARITY_POS=17.
- One natural sub-module, rx_byte_packer: serial-to-byte assembler with valid and clear.

Test Plan:
- Good frame, rate bits 1,1,0,1, length=2, parity 0, SERVICE all 0, data bits 0xA5 then 0x3C (LSB-first) -> rate=0xB, length=2, hdr_valid at cycle 24, byte_out 0xA5 then 0x3C, frame_done with the second byte.
- Same frame with parity bit 1 -> hdr_err at cycle 24, ds_reset_n low next cycle, no byte_valid, busy=0.
- Header with length=0, or with R4=0 -> hdr_err; descrambler held in reset.
- bit_valid dropped for 1 cycle during DATA byte 0 -> frame_abort, no byte_valid, IDLE; next good frame decodes correctly.
- sof reasserted during SERVICE -> frame_abort, no new frame started.
- Reset driven low during DATA -> all outputs at reset values; back-to-back frames afterward each decode with a 1-cycle gap.
